// File: rtl/debug_auth_pkg.sv
// Shared definitions for the debug authentication controller: state encoding,
// default unlock key and default attempt/lockout/session limits.
package debug_auth_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHALLENGE = 2'd1,
      GRANTED   = 2'd2,
      LOCKOUT   = 2'd3
   } auth_state_t;

   localparam logic [15:0] DEFAULT_KEY            = 16'hA5C3;
   localparam int          DEFAULT_MAX_ATTEMPTS   = 3;
   localparam int          DEFAULT_LOCKOUT_CYCLES = 256;
   localparam int          DEFAULT_SESSION_CYCLES = 1024;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter shared by the lockout and session phases.
// expired is high whenever the remaining count has reached zero.
module auth_timer #(
   parameter int WIDTH = 11
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count,
   output logic             expired
);

   logic [WIDTH-1:0] remaining;

   // Load wins over counting; counting stops at zero so it never wraps.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= load_value;
      end else if (count && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign expired = (remaining == '0);

endmodule

// File: rtl/debug_auth_ctrl.sv
// Debug access gate: a requester must present the unlock key before the
// locked register is told it is in trusted debug mode. Repeated wrong keys
// trigger a fixed-length lockout, and granted sessions are time-limited.
module debug_auth_ctrl
   import debug_auth_pkg::*;
#(
   parameter logic [15:0] KEY            = DEFAULT_KEY,
   parameter int          MAX_ATTEMPTS   = DEFAULT_MAX_ATTEMPTS,
   parameter int          LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
   parameter int          SESSION_CYCLES = DEFAULT_SESSION_CYCLES
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        debug_req,
   input  logic        key_valid,
   input  logic [15:0] key_in,
   input  logic        debug_exit,
   output logic        debug_mode,
   output logic        trusted,
   output logic        auth_fail,
   output logic        locked_out,
   output logic [2:0]  fail_count
);

   // One extra bit keeps the timer comfortably wide enough for either load value.
   localparam int TIMER_W = $clog2(max_int(LOCKOUT_CYCLES, SESSION_CYCLES)) + 1;
   localparam logic [TIMER_W-1:0] LOCK_LOAD    = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SESSION_LOAD = TIMER_W'(SESSION_CYCLES - 1);
   localparam logic [3:0]         MAX_FAIL     = 4'(MAX_ATTEMPTS);

   auth_state_t        state;
   auth_state_t        next_state;
   logic [2:0]         fail_next;
   logic [3:0]         fail_inc;
   logic               auth_fail_next;
   logic               grant_q;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_count;
   logic               timer_expired;

   auth_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .Clk       (Clk),
      .reset     (reset),
      .load      (timer_load),
      .load_value(timer_value),
      .count     (timer_count),
      .expired   (timer_expired)
   );

   assign fail_inc    = {1'b0, fail_count} + 4'd1;
   assign timer_count = (state == GRANTED) || (state == LOCKOUT);

   // Next-state, fail counter and timer control; exit/request drop always
   // beat a key strobe so an abandoned challenge never consumes an attempt.
   always_comb begin
      next_state     = state;
      fail_next      = fail_count;
      auth_fail_next = 1'b0;
      timer_load     = 1'b0;
      timer_value    = '0;
      unique case (state)
         IDLE: begin
            if (debug_req && !debug_exit) begin
               next_state = CHALLENGE;
            end
         end
         CHALLENGE: begin
            if (debug_exit || !debug_req) begin
               next_state = IDLE;
            end else if (key_valid) begin
               if (key_in == KEY) begin
                  next_state  = GRANTED;
                  fail_next   = '0;
                  timer_load  = 1'b1;
                  timer_value = SESSION_LOAD;
               end else begin
                  auth_fail_next = 1'b1;
                  if (fail_inc >= MAX_FAIL) begin
                     fail_next   = MAX_FAIL[2:0];
                     next_state  = LOCKOUT;
                     timer_load  = 1'b1;
                     timer_value = LOCK_LOAD;
                  end else begin
                     fail_next = fail_inc[2:0];
                  end
               end
            end
         end
         GRANTED: begin
            if (debug_exit || !debug_req || timer_expired) begin
               next_state = IDLE;
            end
         end
         LOCKOUT: begin
            if (timer_expired) begin
               next_state = IDLE;
               fail_next  = '0;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, counter and output registers; reset clears grant immediately.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fail_count <= '0;
         auth_fail  <= 1'b0;
         locked_out <= 1'b0;
         grant_q    <= 1'b0;
      end else begin
         state      <= next_state;
         fail_count <= fail_next;
         auth_fail  <= auth_fail_next;
         locked_out <= (next_state == LOCKOUT);
         grant_q    <= (next_state == GRANTED);
      end
   end

   assign trusted    = grant_q;
   assign debug_mode = grant_q;

endmodule

// File: tb/tb_debug_auth_ctrl.sv
// Self-checking bench for debug_auth_ctrl: directed vector table, multi-cycle
// corner sequences, then random stimulus against a behavioural model.
module tb_debug_auth_ctrl;

   localparam logic [15:0] KEY  = 16'hA5C3;
   localparam int          MAXA = 3;
   localparam int          LOCK = 256;
   localparam int          SESS = 1024;

   typedef struct {
      logic        req;
      logic        kv;
      logic [15:0] key;
      logic        ex;
      logic        exp_trusted;
      logic        exp_fail;
      logic [2:0]  exp_cnt;
      logic        exp_locked;
   } vec_t;

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic        debug_req = 1'b0;
   logic        key_valid = 1'b0;
   logic [15:0] key_in = 16'h0000;
   logic        debug_exit = 1'b0;
   logic        debug_mode;
   logic        trusted;
   logic        auth_fail;
   logic        locked_out;
   logic [2:0]  fail_count;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: remaining lockout/session cycles, challenge flag, failures.
   int m_lock = 0;
   int m_sess = 0;
   int m_chal = 0;
   int m_fails = 0;
   int m_auth = 0;

   vec_t table_v[11];

   debug_auth_ctrl #(
      .KEY(KEY),
      .MAX_ATTEMPTS(MAXA),
      .LOCKOUT_CYCLES(LOCK),
      .SESSION_CYCLES(SESS)
   ) dut (
      .Clk(Clk),
      .reset(reset),
      .debug_req(debug_req),
      .key_valid(key_valid),
      .key_in(key_in),
      .debug_exit(debug_exit),
      .debug_mode(debug_mode),
      .trusted(trusted),
      .auth_fail(auth_fail),
      .locked_out(locked_out),
      .fail_count(fail_count)
   );

   // Free-running 10-unit clock.
   always #5 Clk = ~Clk;

   task automatic check_output(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input int t, input int af, input int cnt, input int lo);
      check_output({tag, ".trusted"}, int'(trusted), t);
      check_output({tag, ".debug_mode"}, int'(debug_mode), t);
      check_output({tag, ".auth_fail"}, int'(auth_fail), af);
      check_output({tag, ".fail_count"}, int'(fail_count), cnt);
      check_output({tag, ".locked_out"}, int'(locked_out), lo);
   endtask

   // Drive inputs just after an edge, then let one rising edge sample them.
   task automatic apply_stimulus(input logic req, input logic kv, input logic [15:0] key, input logic ex);
      debug_req  = req;
      key_valid  = kv;
      key_in     = key;
      debug_exit = ex;
      @(posedge Clk);
      #1;
   endtask

   task automatic model_step(input logic req, input logic kv, input logic [15:0] key, input logic ex);
      m_auth = 0;
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (m_sess > 0) begin
         if (ex || !req) m_sess = 0;
         else m_sess--;
      end else if (m_chal != 0) begin
         if (ex || !req) begin
            m_chal = 0;
         end else if (kv) begin
            if (key == KEY) begin
               m_chal = 0;
               m_sess = SESS;
               m_fails = 0;
            end else begin
               m_fails++;
               m_auth = 1;
               if (m_fails >= MAXA) begin
                  m_chal = 0;
                  m_lock = LOCK;
               end
            end
         end
      end else if (req && !ex) begin
         m_chal = 1;
      end
   endtask

   task automatic pulse_reset();
      @(posedge Clk);
      #2;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      int lock_cycles;
      int sess_cycles;
      int grant_seen;
      logic [6:0] act;
      logic [6:0] expv;
      logic rq, kv, ex;
      logic [15:0] ky;

      table_v[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      table_v[1]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      table_v[2]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0};
      table_v[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
      table_v[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
      table_v[5]  = '{1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
      table_v[6]  = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
      table_v[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
      table_v[8]  = '{1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
      table_v[9]  = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
      table_v[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

      // Reset state, sampled while reset is still held.
      repeat (2) @(posedge Clk);
      #1;
      check_all("reset", 0, 0, 0, 0);
      reset = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(table_v[i].req, table_v[i].kv, table_v[i].key, table_v[i].ex);
         check_all($sformatf("vec%0d", i), int'(table_v[i].exp_trusted), int'(table_v[i].exp_fail),
                   int'(table_v[i].exp_cnt), int'(table_v[i].exp_locked));
      end

      // Three wrong keys, then a lockout that ignores key and exit.
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      apply_stimulus(1'b1, 1'b1, 16'h0001, 1'b0);
      check_all("lock_k1", 0, 1, 1, 0);
      apply_stimulus(1'b1, 1'b1, 16'h0002, 1'b0);
      check_all("lock_k2", 0, 1, 2, 0);
      apply_stimulus(1'b1, 1'b1, 16'h0003, 1'b0);
      check_all("lock_k3", 0, 1, 3, 1);
      lock_cycles = 1;
      grant_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         apply_stimulus(1'b1, 1'b1, KEY, 1'(i % 2));
         if (trusted) grant_seen = 1;
         if (!locked_out) break;
         lock_cycles++;
      end
      check_output("lockout_len", lock_cycles, LOCK);
      check_output("lockout_no_grant", grant_seen, 0);
      check_all("lock_end", 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);

      // Session held open until the timer closes it.
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      check_output("sess_pre_trusted", int'(trusted), 0);
      apply_stimulus(1'b1, 1'b1, KEY, 1'b0);
      check_all("sess_grant", 1, 0, 0, 0);
      sess_cycles = 1;
      for (int i = 0; i < 2000; i++) begin
         apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
         if (!trusted) break;
         sess_cycles++;
      end
      check_output("session_len", sess_cycles, SESS);
      check_output("session_end_dm", int'(debug_mode), 0);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);

      // Reset between edges while granted drops trust before the next edge.
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      apply_stimulus(1'b1, 1'b1, KEY, 1'b0);
      check_output("rst_grant_before", int'(trusted), 1);
      #2;
      reset = 1'b1;
      #1;
      check_output("rst_async_trusted", int'(trusted), 0);
      check_output("rst_async_dm", int'(debug_mode), 0);
      #2;
      reset = 1'b0;
      apply_stimulus(1'b1, 1'b1, KEY, 1'b0);
      check_output("rst_idle_ignores_key", int'(trusted), 0);
      apply_stimulus(1'b1, 1'b1, KEY, 1'b0);
      check_output("rst_regrant", int'(trusted), 1);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);

      // Reset mid-lockout aborts it and clears the failure count.
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 16'h1111, 1'b0);
      repeat (5) apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      check_output("rstlock_locked", int'(locked_out), 1);
      #2;
      reset = 1'b1;
      #1;
      check_output("rstlock_async_lo", int'(locked_out), 0);
      check_output("rstlock_async_cnt", int'(fail_count), 0);
      #2;
      reset = 1'b0;
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      apply_stimulus(1'b1, 1'b1, KEY, 1'b0);
      check_all("rstlock_regrant", 1, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);

      // Random stimulus against the model.
      pulse_reset();
      m_lock = 0; m_sess = 0; m_chal = 0; m_fails = 0; m_auth = 0;
      for (int i = 0; i < 4000; i++) begin
         rq = ($urandom_range(0, 15) != 0);
         ex = ($urandom_range(0, 31) == 0);
         kv = ($urandom_range(0, 2) == 0);
         ky = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
         model_step(rq, kv, ky, ex);
         apply_stimulus(rq, kv, ky, ex);
         act  = {trusted, debug_mode, auth_fail, locked_out, fail_count};
         expv = {(m_sess > 0), (m_sess > 0), (m_auth != 0), (m_lock > 0), 3'(m_fails)};
         check_output($sformatf("rand%0d", i), int'(act), int'(expv));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/debug_auth_ctrl.md
DEBUG_AUTH_CTRL -- requirements
Module: debug_auth_ctrl

Interface
REQ-001 Parameter KEY, 16'hA5C3, the unlock key compared against key_in.
REQ-002 Parameter MAX_ATTEMPTS, 3, the number of wrong keys that triggers lockout (legal range 1..7).
REQ-003 Parameter LOCKOUT_CYCLES, 256, the lockout duration in Clk cycles (at least 2).
REQ-004 Parameter SESSION_CYCLES, 1024, the maximum length of a granted debug session in Clk cycles (at least 2).
REQ-005 Clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 debug_req  input  1  level request to open a debug session.
REQ-008 key_valid  input  1  one-cycle strobe qualifying key_in.
REQ-009 key_in  input  16  the candidate unlock key.
REQ-010 debug_exit  input  1  request to end the session or challenge.
REQ-011 debug_mode  output  1  high while the session is granted; drives the locked register's debug_mode input.
REQ-012 trusted  output  1  high while the session is granted; drives the locked register's trusted input.
REQ-013 auth_fail  output  1  one-cycle pulse per wrong key.
REQ-014 locked_out  output  1  high during lockout.
REQ-015 fail_count  output  3  number of consecutive wrong keys.

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, CHALLENGE, GRANTED, LOCKOUT.
REQ-017 IDLE->CHALLENGE SHALL occur on a cycle with debug_req=1 and debug_exit=0; key_valid in IDLE SHALL be ignored.
REQ-018 CHALLENGE, key_valid=1 with key_in==KEY: next state SHALL be GRANTED, fail_count SHALL clear, and trusted/debug_mode SHALL go high on the next edge (1-cycle latency).
REQ-019 CHALLENGE, key_valid=1 with key_in!=KEY: auth_fail SHALL pulse on the next cycle and fail_count SHALL increment; if the new count equals MAX_ATTEMPTS, next state SHALL be LOCKOUT, otherwise the FSM SHALL stay in CHALLENGE.
REQ-020 CHALLENGE with debug_exit=1 SHALL return to IDLE; debug_exit SHALL win over a simultaneous key_valid, and that key SHALL be neither evaluated nor counted.
REQ-021 CHALLENGE with debug_req deasserted SHALL return to IDLE; fail_count SHALL be retained.
REQ-022 GRANTED SHALL return to IDLE on debug_exit=1, on debug_req=0, or after SESSION_CYCLES cycles in GRANTED, whichever comes first; trusted/debug_mode SHALL be low from the cycle after the transition.
REQ-023 key_valid in GRANTED SHALL be ignored and SHALL NOT alter fail_count.
REQ-024 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, with locked_out high throughout; all inputs SHALL be ignored, including debug_exit.
REQ-025 LOCKOUT expiry SHALL go to IDLE and clear fail_count to 0.
REQ-026 trusted and debug_mode SHALL be registered, always equal, and high only in GRANTED.
REQ-027 fail_count SHALL saturate at MAX_ATTEMPTS and never wrap.
REQ-028 Timer compare arithmetic SHALL use a width of clog2(max(LOCKOUT_CYCLES, SESSION_CYCLES))+1 bits, with no overflow.

Reset
REQ-029 On reset=1, the FSM SHALL go to IDLE, timers and fail_count SHALL be 0, and all outputs SHALL be 0, all asynchronously without waiting for Clk.
REQ-030 A reset asserted mid-GRANTED SHALL drop trusted within the same cycle, and a reset mid-LOCKOUT SHALL abort the lockout.
REQ-031 After reset deasserts, the first state change SHALL occur no earlier than the next rising edge of Clk.

Structure
REQ-032 A package debug_auth_pkg SHALL hold the state enum and the default values of KEY, MAX_ATTEMPTS, LOCKOUT_CYCLES and SESSION_CYCLES.
REQ-033 One sub-module, auth_timer, SHALL be used: a loadable down-counter with load, count and expired ports, shared by LOCKOUT and GRANTED (only one is active at a time).
REQ-034 The top level SHALL contain only the FSM, the fail counter and the output registers.

Verification
REQ-035 The bench SHALL cover: reset; debug_req=1; key 16'hA5C3 strobed -> trusted=1 and debug_mode=1 exactly one cycle after the strobe.
REQ-036 The bench SHALL cover: keys 16'h0001, 16'h0002, 16'h0003 -> three auth_fail pulses, fail_count 1,2,3, and locked_out=1 for 256 cycles, then IDLE with fail_count=0.
REQ-037 The bench SHALL cover: in LOCKOUT, strobing the correct key and debug_exit -> no grant and the lockout length unchanged.
REQ-038 The bench SHALL cover: GRANTED held with debug_req=1 -> trusted falls after exactly 1024 cycles.
REQ-039 The bench SHALL cover: in CHALLENGE, debug_exit and the correct key in the same cycle -> IDLE, trusted=0, fail_count unchanged.
REQ-040 The bench SHALL cover: reset pulsed between clock edges while GRANTED -> trusted=0 before the next edge and the FSM in IDLE.
